// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud timing derivation.
// Used by both the receiver and the FIFO-fed transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        PUSH
    } uart_state_e;

    function automatic int tick_div(int clk_freq, int baud_rate, int oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

    function automatic int mid_point(int oversample);
        return oversample / 2;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample clock enable: one-clk tick every TICK_DIV clocks.
// Shared between the UART receiver and transmitter.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: oversampled, start/stop validated, pushes good bytes
// into a downstream FIFO and reports framing errors and overruns.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       fifo_full,
    output logic [7:0] fifo_out,
    output logic       push_data,
    output logic       donerx,
    output logic       frame_err,
    output logic       overrun
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] MID_M1 = SW'(mid_point(OVERSAMPLE) - 1);
    localparam logic [SW-1:0] LAST   = SW'(OVERSAMPLE - 1);

    logic tick;

    uart_baud_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    uart_state_e   state_q, state_d;
    logic          sync1_q, rx_s_q;
    logic [SW-1:0] samp_q, samp_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          armed_q, armed_d;
    logic [7:0]    fifo_out_q, fifo_out_d;
    logic          push_q, push_d;
    logic          done_q, done_d;
    logic          fe_q, fe_d;
    logic          ov_q, ov_d;

    always_comb begin
        state_d    = state_q;
        samp_d     = samp_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        armed_d    = armed_q;
        fifo_out_d = fifo_out_q;
        push_d     = 1'b0;
        done_d     = 1'b0;
        fe_d       = fe_q;
        ov_d       = ov_q;
        unique case (state_q)
            IDLE: begin
                // armed only after line seen high: no retrigger on low stop/break
                if (rx_s_q) begin
                    armed_d = 1'b1;
                end
                if (tick && armed_q && !rx_s_q) begin
                    state_d = START;
                    samp_d  = SW'(1);
                    armed_d = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    if (samp_q == MID_M1) begin
                        if (rx_s_q) begin
                            state_d = IDLE;
                        end else begin
                            samp_d  = '0;
                            bit_d   = '0;
                            state_d = DATA;
                        end
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (samp_q == LAST) begin
                        samp_d  = '0;
                        shift_d = {rx_s_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (samp_q == LAST) begin
                        samp_d  = '0;
                        state_d = PUSH;
                        done_d  = 1'b1;
                        if (!rx_s_q) begin
                            fe_d = 1'b1;
                        end else if (fifo_full) begin
                            ov_d = 1'b1;
                        end else begin
                            fifo_out_d = shift_q;
                            push_d     = 1'b1;
                        end
                    end else begin
                        samp_d = samp_q + 1'b1;
                    end
                end
            end
            PUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            samp_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            armed_q    <= 1'b0;
            fifo_out_q <= 8'h00;
            push_q     <= 1'b0;
            done_q     <= 1'b0;
            fe_q       <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= rx;
            rx_s_q     <= sync1_q;
            samp_q     <= samp_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            armed_q    <= armed_d;
            fifo_out_q <= fifo_out_d;
            push_q     <= push_d;
            done_q     <= done_d;
            fe_q       <= fe_d;
            ov_q       <= ov_d;
        end
    end

    assign fifo_out  = fifo_out_q;
    assign push_data = push_q;
    assign donerx    = done_q;
    assign frame_err = fe_q;
    assign overrun   = ov_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized frames against a frame-level reference model.
module tb_uart_rx_fifo;

    localparam int CLK_FREQ = 7372800;
    localparam int BAUD     = 115200;
    localparam int OS       = 16;
    localparam int DIV      = CLK_FREQ / (BAUD * OS);
    localparam int BIT      = DIV * OS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       fifo_full = 1'b0;
    logic [7:0] fifo_out;
    logic       push_data;
    logic       donerx;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_q[$];
    int         n_done = 0;

    logic [7:0] exp_q[$];
    int         exp_done = 0;
    logic       exp_fe = 1'b0;
    logic       exp_ov = 1'b0;

    uart_rx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .OVERSAMPLE (OS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .fifo_full (fifo_full),
        .fifo_out  (fifo_out),
        .push_data (push_data),
        .donerx    (donerx),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    function automatic void chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (push_data) begin
                got_q.push_back(fifo_out);
                chk("push_with_donerx", {31'd0, donerx}, 32'd1);
            end
            if (donerx) begin
                n_done++;
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input int gap);
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(BIT);
        end
        rx = stop;
        wait_clks(BIT);
        rx = 1'b1;
        wait_clks(gap * BIT);
    endtask

    // Frame-level expectation: what a receiver must report for one frame
    task automatic frame(input logic [7:0] b, input logic stop,
                         input logic full, input int gap);
        exp_done++;
        if (!stop) begin
            exp_fe = 1'b1;
        end else if (full) begin
            exp_ov = 1'b1;
        end else begin
            exp_q.push_back(b);
        end
        fifo_full = full;
        send(b, stop, gap);
        fifo_full = 1'b0;
    endtask

    task automatic check_step(input string tag);
        chk({tag, "_npush"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            chk({tag, "_byte"}, {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
        end
        got_q.delete();
        exp_q.delete();
        chk({tag, "_ndone"}, n_done, exp_done);
        chk({tag, "_frame_err"}, {31'd0, frame_err}, {31'd0, exp_fe});
        chk({tag, "_overrun"}, {31'd0, overrun}, {31'd0, exp_ov});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fifo_out"}, {24'd0, fifo_out}, 32'h00);
        chk({tag, "_push"}, {31'd0, push_data}, 32'd0);
        chk({tag, "_donerx"}, {31'd0, donerx}, 32'd0);
        chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        logic [7:0] c3;
        logic [7:0] rb;
        logic       rs;
        logic       rf;
        int         rg;

        rst_n = 1'b0;
        wait_clks(5);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_clks(2 * BIT);

        frame(8'hA5, 1'b1, 1'b0, 1);
        check_step("a5");

        frame(8'h00, 1'b1, 1'b0, 0);
        frame(8'hFF, 1'b1, 1'b0, 0);
        frame(8'h3C, 1'b1, 1'b0, 1);
        check_step("b2b");

        rx = 1'b0;
        wait_clks(4 * DIV);
        rx = 1'b1;
        wait_clks(2 * BIT);
        check_step("glitch");
        frame(8'h55, 1'b1, 1'b0, 1);
        check_step("after_glitch");

        frame(8'h81, 1'b0, 1'b0, 2);
        check_step("frame_err");
        frame(8'h12, 1'b1, 1'b0, 1);
        check_step("after_ferr");

        frame(8'h77, 1'b1, 1'b1, 1);
        check_step("overrun");
        frame(8'h78, 1'b1, 1'b0, 1);
        check_step("after_ovr");

        c3 = 8'hC3;
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = c3[i];
            wait_clks(BIT);
        end
        rx = c3[4];
        wait_clks(BIT / 2);
        rst_n = 1'b0;
        rx = 1'b1;
        wait_clks(4);
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        wait_clks(2 * BIT);
        check_step("post_reset");
        frame(8'h5A, 1'b1, 1'b0, 1);
        check_step("after_reset");

        for (int n = 0; n < 24; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 4) != 0);
            rf = ($urandom_range(0, 3) == 0);
            rg = rs ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            frame(rb, rs, rf, rg);
            check_step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
